logic_unit_pipe: RTL and testbench



---
 rtl/logic_unit_pkg.sv | 17 +
 rtl/logic_unit_pipe_if.sv | 34 +++
 rtl/logic_op_alu.sv | 36 +++
 rtl/logic_unit_pipe.sv | 125 ++++++++++++
 tb/tb_logic_unit_pipe.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit: opcode encoding and widths.
package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } opcode_t;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result valid-ready bus of the logic unit. The producer/consumer side
// uses the master modport, the pipeline uses the slave modport.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    // Operand channel
    logic                            in_valid;
    logic                            in_ready;
    logic [logic_unit_pkg::OP_W-1:0] op;
    logic [WIDTH-1:0]                a;
    logic [WIDTH-1:0]                b;

    // Result channel
    logic                            out_valid;
    logic                            out_ready;
    logic [WIDTH-1:0]                y;
    logic                            zero;
    logic                            parity;

    // Status
    logic [CNT_W-1:0]                op_count;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, zero, parity, op_count
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, zero, parity, op_count
    );

endinterface

// File: rtl/logic_op_alu.sv
// Combinational bitwise ALU: applies the selected opcode to two operands and
// derives the zero and parity flags of the result.
module logic_op_alu
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o,
    output logic             zero_o,
    output logic             parity_o
);

    // Opcode decode to the bitwise result
    always_comb begin
        // NOTE: default assignment first so no path leaves y_o unassigned (no latch).
        y_o = '0;
        case (opcode_t'(op_i))
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_NOT:  y_o = ~a_i;
            OP_NAND: y_o = ~(a_i & b_i);
            OP_NOR:  y_o = ~(a_i | b_i);
            OP_XOR:  y_o = a_i ^ b_i;
            OP_XNOR: y_o = ~(a_i ^ b_i);
            OP_PASS: y_o = a_i;
            default: y_o = '0;
        endcase
    end

    assign zero_o   = (y_o == '0);
    assign parity_o = ^y_o;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around logic_op_alu. S1 holds the operands,
// S2 holds the registered result and flags. A saturating counter tracks
// completed output handshakes.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    logic_unit_pipe_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Stage 1: operands
    logic             s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]  s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;

    // Stage 2: result and flags
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_y_q;
    logic             s2_zero_q;
    logic             s2_parity_q;

    // Completed-operation counter
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ALU outputs computed from S1
    logic [WIDTH-1:0] alu_y;
    logic             alu_zero;
    logic             alu_parity;

    // Ready chain and advance strobes
    logic s1_ready;
    logic s2_ready;
    logic s1_load;
    logic s2_load;
    logic out_fire;

    assign s2_ready = !s2_valid_q || bus.out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign s1_load  = bus.in_valid && s1_ready;
    assign s2_load  = s1_valid_q && s2_ready;
    assign out_fire = s2_valid_q && bus.out_ready;

    logic_op_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op_i     (s1_op_q),
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .y_o      (alu_y),
        .zero_o   (alu_zero),
        .parity_o (alu_parity)
    );

    // Next-state of stage valids and the saturating counter
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        cnt_d      = cnt_q;
        if (s1_ready) begin
            s1_valid_d = bus.in_valid;
        end
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
        end
        if (out_fire && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Control state: stage valids and counter
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    // Stage 1 payload loads only on an input handshake
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: payloads are reset too, so y/zero/parity read 0 straight out of reset.
        if (!rst_n) begin
            s1_op_q <= '0;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
        end else if (s1_load) begin
            s1_op_q <= bus.op;
            s1_a_q  <= bus.a;
            s1_b_q  <= bus.b;
        end
    end

    // Stage 2 payload loads only when S1 advances into it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_y_q      <= '0;
            s2_zero_q   <= 1'b0;
            s2_parity_q <= 1'b0;
        end else if (s2_load) begin
            s2_y_q      <= alu_y;
            s2_zero_q   <= alu_zero;
            s2_parity_q <= alu_parity;
        end
    end

    assign bus.in_ready  = s1_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.y         = s2_y_q;
    assign bus.zero      = s2_zero_q;
    assign bus.parity    = s2_parity_q;
    assign bus.op_count  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=8, CNT_W=4): directed
// scenarios followed by random traffic, scored against a queue-based model.
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int CNT_SAT = 15;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             zero;
        logic             parity;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    logic_unit_pipe #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    res_t exp_q[$];
    res_t got_q[$];
    int   exp_cnt  = 0;
    int   cyc      = 0;
    int   n_acc    = 0;
    int   first_acc_cyc = -1;
    int   first_out_cyc = -1;
    bit   stall_prev = 1'b0;
    res_t held;

    // Reference: the opcode table applied with plain operators, flags by counting ones.
    function automatic res_t model(input int op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        res_t r;
        case (op)
            0: r.y = a & b;
            1: r.y = a | b;
            2: r.y = ~a;
            3: r.y = ~(a & b);
            4: r.y = ~(a | b);
            5: r.y = a ^ b;
            6: r.y = ~(a ^ b);
            default: r.y = a;
        endcase
        r.zero   = (r.y == 0);
        r.parity = ($countones(r.y) % 2) == 1;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes before the edge, score, then check the counter after it.
    task automatic tick();
        bit   in_hs;
        bit   out_hs;
        res_t e;
        res_t o;
        @(negedge clk);
        cyc++;
        in_hs  = bus.in_valid && bus.in_ready;
        out_hs = bus.out_valid && bus.out_ready;
        o = '{y: bus.y, zero: bus.zero, parity: bus.parity};
        if (stall_prev) begin
            check("stall_hold", {bus.out_valid, o}, {1'b1, held});
        end
        if (bus.out_valid && first_out_cyc < 0) first_out_cyc = cyc;
        if (out_hs) begin
            got_q.push_back(o);
            if (exp_q.size() == 0) begin
                check("spurious_out", {31'b0, bus.out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", o, e);
            end
            if (exp_cnt < CNT_SAT) exp_cnt++;
        end
        if (in_hs) begin
            exp_q.push_back(model(int'(bus.op), bus.a, bus.b));
            n_acc++;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        held = o;
        @(posedge clk);
        #1;
        check("op_count", 32'(bus.op_count), 32'(exp_cnt));
    endtask

    task automatic drive(input bit v, input int op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.in_valid = v;
        bus.op       = 3'(op);
        bus.a        = a;
        bus.b        = b;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] sweep_y[8];
        int               acc0;
        sweep_y = '{8'h00, 8'hFF, 8'h3A, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hC5};

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 0, '0, '0);
        bus.out_ready = 1'b0;
        #12;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_y", {24'b0, bus.y}, 32'd0);
        check("rst_op_count", 32'(bus.op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Opcode sweep against the fixed expectation table
        bus.out_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i, 8'hC5, 8'h3A);
            tick();
        end
        drain();
        check("sweep_count", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            check($sformatf("sweep_y%0d", i), {24'b0, got_q[i].y}, {24'b0, sweep_y[i]});
            check($sformatf("sweep_zero%0d", i), {31'b0, got_q[i].zero},
                  (i == 0 || i == 4 || i == 6) ? 32'd1 : 32'd0);
            check($sformatf("sweep_par%0d", i), {31'b0, got_q[i].parity}, 32'd0);
        end

        // Latency and throughput: 10 back-to-back XOR beats
        first_acc_cyc = -1;
        first_out_cyc = -1;
        got_q.delete();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5, 8'($urandom), 8'($urandom));
            tick();
            check("thru_in_ready", {31'b0, bus.in_ready}, 32'd1);
        end
        drain();
        check("latency", 32'(first_out_cyc - first_acc_cyc), 32'd2);
        check("thru_count", 32'(got_q.size()), 32'd10);
        check("sat_after_18", 32'(bus.op_count), 32'd15);

        // Backpressure: two beats fill the pipe, the third waits for out_ready
        bus.out_ready = 1'b0;
        acc0 = n_acc;
        drive(1'b1, 0, 8'hF0, 8'h3C);
        tick();
        drive(1'b1, 1, 8'h81, 8'h18);
        tick();
        drive(1'b1, 6, 8'h55, 8'h0F);
        #1;
        check("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
        check("bp_accepted2", 32'(n_acc - acc0), 32'd2);
        check("bp_y_first", {24'b0, bus.y}, 32'h30);
        repeat (3) tick();
        check("bp_still2", 32'(n_acc - acc0), 32'd2);
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_rise", {31'b0, bus.in_ready}, 32'd1);
        tick();
        check("bp_accepted3", 32'(n_acc - acc0), 32'd3);
        drain();
        check("sat_hold", 32'(bus.op_count), 32'd15);

        // Reset with two beats in flight
        bus.out_ready = 1'b0;
        drive(1'b1, 7, 8'hA5, 8'h00);
        tick();
        drive(1'b1, 2, 8'h00, 8'h00);
        tick();
        drive(1'b0, 0, '0, '0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mid_rst_y", {24'b0, bus.y}, 32'd0);
        check("mid_rst_zero", {31'b0, bus.zero}, 32'd0);
        check("mid_rst_parity", {31'b0, bus.parity}, 32'd0);
        check("mid_rst_op_count", 32'(bus.op_count), 32'd0);
        exp_q.delete();
        exp_cnt    = 0;
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("post_rst_op_count", 32'(bus.op_count), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_stale", {31'b0, bus.out_valid}, 32'd0);
        end

        // Random stress against the model queue
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), int'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            bus.out_ready = 1'($urandom);
            tick();
        end
        drain();
        check("final_op_count", 32'(bus.op_count), 32'(exp_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
